// File: rtl/uart_axi_host_if.sv
// AXI-lite style bus between uart_axi_host (master) and the UART peripheral slave port.
`timescale 1ns/1ps
interface uart_axi_host_if;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic        m_wvalid;
    logic        m_wready;
    logic        m_b_valid;
    logic        m_b_ready;
    logic [1:0]  m_b_response;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic        m_rvalid;
    logic        m_rready;

    modport master (
        output m_awaddr, m_awvalid, m_wdata, m_wvalid, m_b_ready, m_araddr, m_arvalid, m_rready,
        input  m_awready, m_wready, m_b_valid, m_b_response, m_arready, m_rdata, m_rvalid
    );

    modport slave (
        input  m_awaddr, m_awvalid, m_wdata, m_wvalid, m_b_ready, m_araddr, m_arvalid, m_rready,
        output m_awready, m_wready, m_b_valid, m_b_response, m_arready, m_rdata, m_rvalid
    );
endinterface

// File: rtl/uart_axi_host.sv
// AXI-lite initiator: local TX bytes become UART writes, RX FIFO is polled into a local byte stream.
// Optional macro UART_AXI_HOST_ERR_CNT_EN adds a saturating 8-bit err_count output.
`timescale 1ns/1ps
module uart_axi_host #(
    parameter logic [31:0] UART_BASE = 32'h0000_0000,
    parameter logic [15:0] POLL_GAP  = 16'd16,
    parameter logic [7:0]  RD_WAIT   = 8'd4,
    parameter logic [15:0] B_TIMEOUT = 16'd2048
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       err,
`ifdef UART_AXI_HOST_ERR_CNT_EN
    output logic [7:0] err_count,
`endif
    uart_axi_host_if.master bus
);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [2:0] {
        R_IDLE = 3'd0,
        R_ADDR = 3'd1,
        R_DATA = 3'd2,
        R_HOLD = 3'd3,
        R_GAP  = 3'd4
    } r_state_t;

    w_state_t    w_state_r;
    r_state_t    r_state_r;
    logic        tx_ready_r;
    logic [7:0]  wdata_r;
    logic        awvalid_r;
    logic        wvalid_r;
    logic        b_ready_r;
    logic        err_r;
    logic [15:0] b_timer_r;
    logic        arvalid_r;
    logic        rready_r;
    logic        rx_valid_r;
    logic [7:0]  rx_data_r;
    logic [7:0]  wait_cnt_r;
    logic [15:0] gap_cnt_r;
    logic        aw_left_s;
    logic        w_left_s;
    logic        rdata_unused_s;

    // A channel is still pending only if its valid is up and its ready was not seen this cycle.
    assign aw_left_s      = awvalid_r & ~bus.m_awready;
    assign w_left_s       = wvalid_r & ~bus.m_wready;
    assign rdata_unused_s = ^bus.m_rdata[31:8];

    assign tx_ready      = tx_ready_r;
    assign rx_data       = rx_data_r;
    assign rx_valid      = rx_valid_r;
    assign err           = err_r;
    assign bus.m_awaddr  = UART_BASE;
    assign bus.m_araddr  = UART_BASE;
    assign bus.m_awvalid = awvalid_r;
    assign bus.m_wdata   = {24'h00_0000, wdata_r};
    assign bus.m_wvalid  = wvalid_r;
    assign bus.m_b_ready = b_ready_r;
    assign bus.m_arvalid = arvalid_r;
    assign bus.m_rready  = rready_r;

    // Write FSM: one byte per AXI write, response or timeout closes the transaction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state_r  <= W_IDLE;
            tx_ready_r <= 1'b1;
            wdata_r    <= 8'h00;
            awvalid_r  <= 1'b0;
            wvalid_r   <= 1'b0;
            b_ready_r  <= 1'b0;
            err_r      <= 1'b0;
            b_timer_r  <= 16'd0;
        end else begin
            err_r <= 1'b0;
            case (w_state_r)
                W_IDLE: begin
                    // tx_ready is low on the re-entry cycle, so a byte is only taken once it is back up.
                    if (tx_ready_r && tx_valid) begin
                        wdata_r    <= tx_data;
                        awvalid_r  <= 1'b1;
                        wvalid_r   <= 1'b1;
                        tx_ready_r <= 1'b0;
                        w_state_r  <= W_ADDR;
                    end else begin
                        tx_ready_r <= 1'b1;
                    end
                end
                W_ADDR: begin
                    if (awvalid_r && bus.m_awready) begin
                        awvalid_r <= 1'b0;
                    end
                    if (wvalid_r && bus.m_wready) begin
                        wvalid_r <= 1'b0;
                    end
                    if (!aw_left_s && !w_left_s) begin
                        b_ready_r <= 1'b1;
                        b_timer_r <= 16'd0;
                        w_state_r <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bus.m_b_valid) begin
                        b_ready_r <= 1'b0;
                        err_r     <= (bus.m_b_response != 2'b00);
                        w_state_r <= W_IDLE;
                    end else if (b_timer_r == B_TIMEOUT - 16'd1) begin
                        b_ready_r <= 1'b0;
                        err_r     <= 1'b1;
                        w_state_r <= W_IDLE;
                    end else begin
                        b_timer_r <= b_timer_r + 16'd1;
                    end
                end
                default: begin
                    tx_ready_r <= 1'b0;
                    awvalid_r  <= 1'b0;
                    wvalid_r   <= 1'b0;
                    b_ready_r  <= 1'b0;
                    w_state_r  <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: poll the RX FIFO, hold a returned byte until consumed, back off when empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_r  <= R_IDLE;
            arvalid_r  <= 1'b0;
            rready_r   <= 1'b0;
            rx_valid_r <= 1'b0;
            rx_data_r  <= 8'h00;
            wait_cnt_r <= 8'd0;
            gap_cnt_r  <= 16'd0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (!rx_valid_r) begin
                        arvalid_r <= 1'b1;
                        r_state_r <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (bus.m_arready) begin
                        arvalid_r  <= 1'b0;
                        rready_r   <= 1'b1;
                        wait_cnt_r <= 8'd0;
                        r_state_r  <= R_DATA;
                    end
                end
                R_DATA: begin
                    // rready drops on the capturing edge so the slave pops exactly one byte.
                    if (bus.m_rvalid) begin
                        rx_data_r  <= bus.m_rdata[7:0];
                        rx_valid_r <= 1'b1;
                        rready_r   <= 1'b0;
                        r_state_r  <= R_HOLD;
                    end else if (wait_cnt_r == RD_WAIT - 8'd1) begin
                        rready_r  <= 1'b0;
                        gap_cnt_r <= 16'd0;
                        r_state_r <= R_GAP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                R_HOLD: begin
                    if (rx_ready) begin
                        rx_valid_r <= 1'b0;
                        r_state_r  <= R_IDLE;
                    end
                end
                R_GAP: begin
                    if (gap_cnt_r == POLL_GAP - 16'd1) begin
                        r_state_r <= R_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 16'd1;
                    end
                end
                default: begin
                    arvalid_r  <= 1'b0;
                    rready_r   <= 1'b0;
                    rx_valid_r <= 1'b0;
                    r_state_r  <= R_IDLE;
                end
            endcase
        end
    end

`ifdef UART_AXI_HOST_ERR_CNT_EN
    logic [7:0] err_count_r;

    // Saturating tally of err pulses; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_count_r <= 8'h00;
        end else if (err_r && (err_count_r != 8'hFF)) begin
            err_count_r <= err_count_r + 8'h01;
        end
    end

    assign err_count = err_count_r;
`endif

endmodule

// File: tb/tb_uart_axi_host.sv
// Scoreboard bench for uart_axi_host: directed stimulus, queued expectations, negedge monitors.
`timescale 1ns/1ps
module tb_uart_axi_host;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       err;
`ifdef UART_AXI_HOST_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    uart_axi_host_if bus ();

    uart_axi_host dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .err      (err),
`ifdef UART_AXI_HOST_ERR_CNT_EN
        .err_count(err_count),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_w_q[$];
    logic [7:0]  exp_rx_q[$];
    int          exp_err_q[$];
    int          aw_hs = 0;
    int          pop_cnt = 0;
    logic [7:0]  slv_fifo [0:3];
    int          slv_cnt = 0;

    // Slave read port: data is offered only while the host is ready and the FIFO holds a byte.
    assign bus.m_rvalid = bus.m_rready && (slv_cnt > 0);
    assign bus.m_rdata  = {24'h00_0000, slv_fifo[0]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected none", name, act);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        while (!tx_ready && n < 50) begin
            step;
            n++;
        end
        chk("tx_ready_wait", 32'(tx_ready), 32'd1);
        exp_w_q.push_back({24'h00_0000, b});
        tx_data  = b;
        tx_valid = 1'b1;
        step;
        tx_valid = 1'b0;
    endtask

    task automatic wait_bready(output int start);
        int n = 0;
        while (!bus.m_b_ready && n < 20) begin
            step;
            n++;
        end
        chk("b_ready_wait", 32'(bus.m_b_ready), 32'd1);
        start = cyc;
    endtask

    task automatic poll_measure(output int hi, output int gap);
        int n = 0;
        while (bus.m_rready && n < 60) begin
            @(negedge clk);
            n++;
        end
        while (!bus.m_rready && n < 120) begin
            @(negedge clk);
            n++;
        end
        hi = 0;
        while (bus.m_rready && hi < 60) begin
            hi++;
            @(negedge clk);
        end
        gap = 0;
        while (!bus.m_arvalid && gap < 60) begin
            gap++;
            @(negedge clk);
        end
    endtask

    // Write-channel and err monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.m_awvalid && bus.m_awready) aw_hs++;
            if (bus.m_wvalid && bus.m_wready) begin
                if (exp_w_q.size() == 0) fail_evt("unexpected_write", bus.m_wdata);
                else chk("wdata", bus.m_wdata, exp_w_q.pop_front());
            end
            if (err) begin
                if (exp_err_q.size() == 0) fail_evt("unexpected_err", 32'(cyc));
                else chk("err_cycle", 32'(cyc), 32'(exp_err_q.pop_front()));
            end
            if (rx_valid && rx_ready) begin
                if (exp_rx_q.size() == 0) fail_evt("unexpected_rx", 32'(rx_data));
                else chk("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
            end
        end
    end

    // Slave FIFO pop: a byte leaves on each edge that sees rvalid & rready.
    initial begin
        logic p;
        forever begin
            @(negedge clk);
            p = bus.m_rvalid;
            @(posedge clk);
            #1;
            if (p) begin
                for (int i = 0; i < 3; i++) slv_fifo[i] = slv_fifo[i + 1];
                slv_cnt--;
                pop_cnt++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int a0, p0, s, hi, gap, n;
        logic ok;
        rst = 1'b0;
        tx_data = 8'h00;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        bus.m_awready = 1'b0;
        bus.m_wready = 1'b0;
        bus.m_b_valid = 1'b0;
        bus.m_b_response = 2'b00;
        bus.m_arready = 1'b1;
        for (int i = 0; i < 4; i++) slv_fifo[i] = 8'h00;
        repeat (3) step;
        chk("reset_valids", 32'({bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_rready,
                                 bus.m_b_ready, rx_valid, err}), 32'd0);
        chk("reset_tx_ready", 32'(tx_ready), 32'd1);
        chk("reset_wdata", bus.m_wdata, 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'd0);
        chk("awaddr", bus.m_awaddr, 32'h0000_0000);
        chk("araddr", bus.m_araddr, 32'h0000_0000);
        rst = 1'b1;
        step;

        // 1: single write, response 900 cycles after b_ready.
        bus.m_awready = 1'b1;
        bus.m_wready = 1'b1;
        a0 = aw_hs;
        send(8'hA5);
        chk("t1_tx_ready_low", 32'(tx_ready), 32'd0);
        wait_bready(s);
        ok = 1'b1;
        repeat (900) begin
            if (!bus.m_b_ready) ok = 1'b0;
            step;
        end
        chk("t1_b_ready_held", 32'(ok), 32'd1);
        bus.m_b_valid = 1'b1;
        step;
        bus.m_b_valid = 1'b0;
        chk("t1_b_ready_drop", 32'(bus.m_b_ready), 32'd0);
        chk("t1_tx_ready_reentry", 32'(tx_ready), 32'd0);
        step;
        chk("t1_tx_ready_back", 32'(tx_ready), 32'd1);
        chk("t1_one_aw", 32'(aw_hs - a0), 32'd1);

        // 2: awready on cycle 2, wready on cycle 5.
        bus.m_awready = 1'b0;
        bus.m_wready = 1'b0;
        a0 = aw_hs;
        send(8'h5A);
        step;
        chk("t2_pending", 32'({bus.m_awvalid, bus.m_wvalid}), 32'd3);
        bus.m_awready = 1'b1;
        step;
        bus.m_awready = 1'b0;
        chk("t2_aw_drop", 32'({bus.m_awvalid, bus.m_wvalid}), 32'd1);
        step;
        step;
        chk("t2_w_hold", 32'({bus.m_wvalid, bus.m_b_ready}), 32'd2);
        bus.m_wready = 1'b1;
        step;
        bus.m_wready = 1'b0;
        chk("t2_w_drop", 32'({bus.m_awvalid, bus.m_wvalid, bus.m_b_ready}), 32'd1);
        bus.m_b_valid = 1'b1;
        step;
        bus.m_b_valid = 1'b0;
        step;
        chk("t2_one_aw", 32'(aw_hs - a0), 32'd1);

        // 3a: SLVERR response gives one err pulse the cycle after b_valid is seen.
        bus.m_awready = 1'b1;
        bus.m_wready = 1'b1;
        send(8'h11);
        wait_bready(s);
        bus.m_b_valid = 1'b1;
        bus.m_b_response = 2'b10;
        exp_err_q.push_back(cyc + 1);
        step;
        bus.m_b_valid = 1'b0;
        bus.m_b_response = 2'b00;
        step;
        step;
`ifdef UART_AXI_HOST_ERR_CNT_EN
        chk("t3a_err_count", 32'(err_count), 32'd1);
`endif

        // 3b: no response: err 2048 cycles after W_RESP entry, tx_ready the cycle after.
        send(8'h22);
        wait_bready(s);
        exp_err_q.push_back(s + 2048);
        while (cyc < s + 2048) step;
        chk("t3b_err", 32'(err), 32'd1);
        chk("t3b_tx_ready_low", 32'(tx_ready), 32'd0);
        step;
        chk("t3b_tx_ready", 32'(tx_ready), 32'd1);
        step;
`ifdef UART_AXI_HOST_ERR_CNT_EN
        chk("t3b_err_count", 32'(err_count), 32'd2);
`endif

        // 4: two queued RX bytes, consumer stalls for 20 cycles.
        rx_ready = 1'b0;
        p0 = pop_cnt;
        slv_fifo[0] = 8'h3C;
        slv_fifo[1] = 8'h7E;
        slv_cnt = 2;
        exp_rx_q.push_back(8'h3C);
        exp_rx_q.push_back(8'h7E);
        n = 0;
        while (!rx_valid && n < 60) begin
            step;
            n++;
        end
        chk("t4_rx_valid", 32'(rx_valid), 32'd1);
        ok = 1'b1;
        repeat (20) begin
            if (!rx_valid || rx_data !== 8'h3C) ok = 1'b0;
            step;
        end
        chk("t4_hold", 32'(ok), 32'd1);
        chk("t4_single_pop", 32'(pop_cnt - p0), 32'd1);
        rx_ready = 1'b1;
        n = 0;
        while (exp_rx_q.size() != 0 && n < 60) begin
            step;
            n++;
        end
        rx_ready = 1'b0;
        repeat (3) step;
        chk("t4_rx_drained", 32'(exp_rx_q.size()), 32'd0);
        chk("t4_total_pops", 32'(pop_cnt - p0), 32'd2);

        // 5: empty FIFO: 4-cycle rready window, then 16 gap cycles plus the R_IDLE issue cycle.
        for (int k = 0; k < 2; k++) begin
            poll_measure(hi, gap);
            chk("t5_rready_cycles", 32'(hi), 32'd4);
            chk("t5_poll_gap", 32'(gap), 32'd17);
        end
        chk("t5_rx_valid_low", 32'(rx_valid), 32'd0);
        step;

        // 6: reset while the write waits in W_RESP and a poll sits in R_DATA.
        bus.m_awready = 1'b1;
        bus.m_wready = 1'b1;
        send(8'h66);
        wait_bready(s);
        n = 0;
        while (!bus.m_rready && n < 60) begin
            step;
            n++;
        end
        chk("t6_in_r_data", 32'({bus.m_rready, bus.m_b_ready}), 32'd3);
        rst = 1'b0;
        step;
        chk("t6_valids", 32'({bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_rready,
                              bus.m_b_ready, rx_valid, err}), 32'd0);
        chk("t6_tx_ready", 32'(tx_ready), 32'd1);
`ifdef UART_AXI_HOST_ERR_CNT_EN
        chk("t6_err_count", 32'(err_count), 32'd0);
`endif
        rst = 1'b1;
        repeat (30) step;
        chk("w_queue_empty", 32'(exp_w_q.size()), 32'd0);
        chk("err_queue_empty", 32'(exp_err_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
